maze_autosolver: RTL
====================

Name: maze_autosolver

Overview:
- Automatic left-hand wall-follower that walks a finished maze from start to finish, one cell per slow tick.
- Sits downstream of the maze carver and consumes its packed maze bitmap and start/finish coordinates.
- Drives a solver position to the renderer's character-position mux, in the same way as the player mover does.
- Reports solved/failed status and a step count for the state controller and the debug LEDs.

Parameters:
- MAZE_W, 16, maximum maze columns (bitmap width).
- MAZE_H, 16, maximum maze rows.
- COORD_W, 4, coordinate width, clog2 of max(MAZE_W, MAZE_H).
- STEP_W, 16, step counter width.
- MAX_STEPS, 1024, step limit; reaching it without arriving at the finish declares failure.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin solving; ignored while busy
- slow_time  in  26  clock cycles per move; 0 is treated as 1
- maze_data  in  MAZE_W*MAZE_H  bit index y*MAZE_W+x; 1 = open cell, 0 = wall
- maze_width  in  5  active columns, 1..MAZE_W
- maze_height  in  5  active rows, 1..MAZE_H
- start_x, start_y  in  COORD_W each  entry cell
- finish_x, finish_y  in  COORD_W each  exit cell
- curr_x, curr_y  out  COORD_W each  solver position
- heading  out  2  0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1)
- step_valid  out  1  one-cycle pulse when curr_x/curr_y change
- step_count  out  STEP_W  moves taken in this run
- busy  out  1  run in progress
- solved  out  1  sticky: finish reached
- failed  out  1  sticky: unsolvable or limit hit

Behaviour:
- Reset values: curr 0,0; heading 1; step_valid 0; step_count 0; busy 0; solved 0; failed 0; timer 0; state IDLE.
- Reset mid-run aborts immediately to the reset values.
- States: IDLE, RUN, DONE, FAIL.
- IDLE/DONE/FAIL + start:
  - next edge: curr <= start, heading <= 1, step_count <= 0, timer <= 0, solved/failed <= 0.
  - Start cell closed (bit 0) -> FAIL (failed=1 that edge, busy stays 0).
  - Else start==finish -> DONE (solved=1, busy=0).
  - Else -> RUN, busy=1.
- RUN, timer: counts 0..max(slow_time,1)-1. On the terminal count the timer wraps to 0 and one move is evaluated.
- Neighbour rule: a neighbour is open only if it is in-bounds (x<maze_width, y<maze_height, no underflow below 0) AND its bitmap bit is 1.
- Move order: left (heading-1), forward, right (heading+1), back (heading+2), all mod 4. The first open candidate wins. heading <= that direction; curr <= that neighbour; step_count +1; step_valid=1 for that cycle only.
- No candidate open (isolated cell) -> FAIL, no move, no pulse.
- After a move:
  - New curr == finish -> DONE, solved=1, busy=0, in the same edge as the move.
  - Else if the new step_count == MAX_STEPS -> FAIL, failed=1, busy=0.
  - Finish takes priority when both are true.
- start while in RUN is ignored. start on the same edge that RUN enters DONE/FAIL is ignored.
- DONE/FAIL hold curr, heading and step_count until the next start or reset.
- Inputs maze_data, width/height and start/finish are sampled live every move. The upstream stage holds them stable while busy.
- step_count saturates at all-ones, which is only reachable if MAX_STEPS is at least 2^STEP_W.

Test Plan:
- Corridor (0,0)-(5,0) open, rest closed, start (0,0), finish (5,0), slow_time=1, pulse start -> busy the cycle after start; step_valid on 5 consecutive cycles; curr_x 1..5; solved=1, step_count=5, heading=1, busy=0.
- T-junction: open (1,0), (1,1), (0,1), (2,1), (1,2); start (1,0), heading E, finish (2,1) -> first move is S to (1,1) (heading 2); second move is E to (2,1) (left of S); solved with step_count=2.
- Dead-end corridor (0,0)-(3,0), finish (5,0) closed, MAX_STEPS=16 -> walker bounces between ends; failed=1 when step_count=16; solved=0.
- Start cell closed -> failed=1 one edge after start; step_count=0; no step_valid. Start==finish, open -> solved=1, step_count=0.
- slow_time=3, corridor run -> step_valid exactly every 3rd cycle. A start pulse mid-run changes nothing. Asserting reset between moves 2 and 3 -> all outputs return to reset values asynchronously, and no further pulses occur.
- Bounds: maze_width=4, start (3,0) heading E, (4,0) bit=1 but out of bounds -> the move is not E; it takes the next open in-bounds candidate.

Source files
------------

// File: rtl/maze_autosolver_if.sv
// Solver-facing bundle: maze description and run control in, walker position and status out.
interface maze_autosolver_if #(
  parameter int MAZE_W  = 16,
  parameter int MAZE_H  = 16,
  parameter int COORD_W = 4,
  parameter int STEP_W  = 16
);
  logic                      start;
  logic [25:0]               slow_time;
  logic [MAZE_W*MAZE_H-1:0]  maze_data;
  logic [4:0]                maze_width;
  logic [4:0]                maze_height;
  logic [COORD_W-1:0]        start_x;
  logic [COORD_W-1:0]        start_y;
  logic [COORD_W-1:0]        finish_x;
  logic [COORD_W-1:0]        finish_y;
  logic [COORD_W-1:0]        curr_x;
  logic [COORD_W-1:0]        curr_y;
  logic [1:0]                heading;
  logic                      step_valid;
  logic [STEP_W-1:0]         step_count;
  logic                      busy;
  logic                      solved;
  logic                      failed;

  modport master (
    output start, slow_time, maze_data, maze_width, maze_height,
           start_x, start_y, finish_x, finish_y,
    input  curr_x, curr_y, heading, step_valid, step_count, busy, solved, failed
  );

  modport slave (
    input  start, slow_time, maze_data, maze_width, maze_height,
           start_x, start_y, finish_x, finish_y,
    output curr_x, curr_y, heading, step_valid, step_count, busy, solved, failed
  );
endinterface

// File: rtl/maze_autosolver.sv
// Left-hand wall follower: walks the carved maze from start to finish, one cell per slow tick.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | walking, one move per timer wrap
// DONE  | finish reached, position held
// FAIL  | start closed, walker boxed in, or step limit hit
module maze_autosolver #(
  parameter int MAZE_W    = 16,
  parameter int MAZE_H    = 16,
  parameter int COORD_W   = 4,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  maze_autosolver_if.slave   bus
);

  localparam int IDX_W = $clog2(MAZE_W * MAZE_H);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  state_t               state, state_next;
  logic [COORD_W-1:0]   curr_x, curr_y, x_next, y_next;
  logic [1:0]           heading, heading_next;
  logic [STEP_W-1:0]    step_count, step_next, step_inc;
  logic [25:0]          timer, timer_next, period_last;
  logic                 step_valid, step_valid_next;
  logic                 tick, start_open, at_limit;

  logic                 move_found;
  logic [1:0]           move_dir, cand_dir;
  logic [COORD_W-1:0]   mv_x, mv_y;
  int                   nx, ny;

  // Open means inside the active area and marked open in the bitmap.
  function automatic logic cell_open(input logic [MAZE_W*MAZE_H-1:0] bits,
                                     input logic [4:0] w, input logic [4:0] h,
                                     input int x, input int y);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(y * MAZE_W + x);
    return (x >= 0) && (y >= 0) && (x < MAZE_W) && (y < MAZE_H) &&
           (x < int'(w)) && (y < int'(h)) && bits[idx];
  endfunction

  assign period_last = (bus.slow_time == 26'd0) ? 26'd0 : bus.slow_time - 26'd1;
  assign tick        = (timer == period_last);
  assign start_open  = bus.maze_data[IDX_W'(int'(bus.start_y) * MAZE_W + int'(bus.start_x))];
  assign step_inc    = (&step_count) ? step_count : step_count + 1'b1;
  assign at_limit    = (64'(step_inc) == 64'(MAX_STEPS));

  // Candidates in priority order left, forward, right, back: offsets 3,0,1,2 mod 4.
  always_comb begin
    move_found = 1'b0;
    move_dir   = heading;
    mv_x       = curr_x;
    mv_y       = curr_y;
    cand_dir   = heading;
    nx         = 0;
    ny         = 0;
    for (int k = 0; k < 4; k++) begin
      cand_dir = heading + 2'(k + 3);
      nx = int'(curr_x) + ((cand_dir == 2'd1) ? 1 : (cand_dir == 2'd3) ? -1 : 0);
      ny = int'(curr_y) + ((cand_dir == 2'd2) ? 1 : (cand_dir == 2'd0) ? -1 : 0);
      if (!move_found && cell_open(bus.maze_data, bus.maze_width, bus.maze_height, nx, ny)) begin
        move_found = 1'b1;
        move_dir   = cand_dir;
        mv_x       = COORD_W'(nx);
        mv_y       = COORD_W'(ny);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      curr_x     <= '0;
      curr_y     <= '0;
      heading    <= 2'd1;
      step_count <= '0;
      timer      <= '0;
      step_valid <= 1'b0;
    end else begin
      state      <= state_next;
      curr_x     <= x_next;
      curr_y     <= y_next;
      heading    <= heading_next;
      step_count <= step_next;
      timer      <= timer_next;
      step_valid <= step_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    x_next          = curr_x;
    y_next          = curr_y;
    heading_next    = heading;
    step_next       = step_count;
    timer_next      = timer;
    step_valid_next = 1'b0;
    case (state)
      RUN: begin
        if (tick) begin
          timer_next = '0;
          if (!move_found) begin
            state_next = FAIL;
          end else begin
            x_next          = mv_x;
            y_next          = mv_y;
            heading_next    = move_dir;
            step_next       = step_inc;
            step_valid_next = 1'b1;
            // Arriving at the finish wins over hitting the step limit.
            if (mv_x == bus.finish_x && mv_y == bus.finish_y)
              state_next = DONE;
            else if (at_limit)
              state_next = FAIL;
          end
        end else begin
          timer_next = timer + 26'd1;
        end
      end
      default: begin
        if (bus.start) begin
          x_next       = bus.start_x;
          y_next       = bus.start_y;
          heading_next = 2'd1;
          step_next    = '0;
          timer_next   = '0;
          if (!start_open)
            state_next = FAIL;
          else if (bus.start_x == bus.finish_x && bus.start_y == bus.finish_y)
            state_next = DONE;
          else
            state_next = RUN;
        end
      end
    endcase
  end

  always_comb begin
    bus.curr_x     = curr_x;
    bus.curr_y     = curr_y;
    bus.heading    = heading;
    bus.step_count = step_count;
    bus.step_valid = step_valid;
    bus.busy       = (state == RUN);
    bus.solved     = (state == DONE);
    bus.failed     = (state == FAIL);
  end

endmodule
